// File: rtl/dec.sv
// RV64I decode stage with a 2-entry skid buffer between fetch and issue/execute.
// Define DEC_RV64M_EN to decode the M extension (MUL/DIV/REM) instead of trapping it as illegal.
module dec #(
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_dec_pc,
  input  logic [31:0]     if_dec_instr,
  input  logic            if_dec_valid,
  output logic            if_dec_ready,
  input  logic            pipe_flush,
  output logic [PC_W-1:0] dec_ix_pc,
  output logic [3:0]      dec_ix_op_type,
  output logic [4:0]      dec_ix_rs1,
  output logic [4:0]      dec_ix_rs2,
  output logic [4:0]      dec_ix_rd,
  output logic            dec_ix_rs1_en,
  output logic            dec_ix_rs2_en,
  output logic            dec_ix_rd_wen,
  output logic [2:0]      dec_ix_funct3,
  output logic            dec_ix_alt,
  output logic            dec_ix_word,
  output logic [63:0]     dec_ix_imm,
  output logic            dec_ix_legal,
  output logic            dec_ix_valid,
  input  logic            ix_dec_ready
);

`ifdef DEC_RV64M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    OP_INT = 4'd0, OP_BRANCH = 4'd1, OP_JAL = 4'd2, OP_JALR = 4'd3,
    OP_LOAD = 4'd4, OP_STORE = 4'd5, OP_LUI = 4'd6, OP_AUIPC = 4'd7,
    OP_MULDIV = 4'd8, OP_SYSTEM = 4'd9, OP_FENCE = 4'd10, OP_ILLEGAL = 4'd15
  } op_type_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    op_type_e        op_type;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_wen;
    logic [2:0]      funct3;
    logic            alt;
    logic            word;
    logic [63:0]     imm;
    logic            legal;
  } bundle_t;

  logic [31:0] ins;
  logic [6:0]  funct7;
  logic [2:0]  f3;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;
  bundle_t     in_dec;

  assign ins    = if_dec_instr;
  assign funct7 = ins[31:25];
  assign f3     = ins[14:12];
  assign imm_i  = {{52{ins[31]}}, ins[31:20]};
  assign imm_s  = {{52{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {{32{ins[31]}}, ins[31:12], 12'b0};
  assign imm_j  = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  always_comb begin : decode
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    in_dec        = '0;
    illegal       = 1'b0;
    in_dec.pc     = if_dec_pc;
    in_dec.rs1    = ins[19:15];
    in_dec.rs2    = ins[24:20];
    in_dec.rd     = ins[11:7];
    in_dec.funct3 = f3;
    unique case (ins[6:0])
      7'b0110111: begin in_dec.op_type = OP_LUI;   in_dec.rd_wen = 1'b1; in_dec.imm = imm_u; end
      7'b0010111: begin in_dec.op_type = OP_AUIPC; in_dec.rd_wen = 1'b1; in_dec.imm = imm_u; end
      7'b1101111: begin in_dec.op_type = OP_JAL;   in_dec.rd_wen = 1'b1; in_dec.imm = imm_j; end
      7'b1100111: begin
        in_dec.op_type = OP_JALR; in_dec.rs1_en = 1'b1; in_dec.rd_wen = 1'b1; in_dec.imm = imm_i;
      end
      7'b1100011: begin
        in_dec.op_type = OP_BRANCH; in_dec.rs1_en = 1'b1; in_dec.rs2_en = 1'b1; in_dec.imm = imm_b;
      end
      7'b0000011: begin
        in_dec.op_type = OP_LOAD; in_dec.rs1_en = 1'b1; in_dec.rd_wen = 1'b1; in_dec.imm = imm_i;
      end
      7'b0100011: begin
        in_dec.op_type = OP_STORE; in_dec.rs1_en = 1'b1; in_dec.rs2_en = 1'b1; in_dec.imm = imm_s;
      end
      7'b0010011: begin
        in_dec.op_type = OP_INT; in_dec.rs1_en = 1'b1; in_dec.rd_wen = 1'b1; in_dec.imm = imm_i;
        // RV64 shift-immediates carry a 6-bit shamt, so only instr[31:26] is funct6.
        if (f3 == 3'b001) illegal = (ins[31:26] != 6'b000000);
        else if (f3 == 3'b101) begin
          illegal    = (ins[31:26] != 6'b000000) && (ins[31:26] != 6'b010000);
          in_dec.alt = ins[30];
        end
      end
      7'b0011011: begin
        in_dec.op_type = OP_INT; in_dec.rs1_en = 1'b1; in_dec.rd_wen = 1'b1;
        in_dec.imm = imm_i; in_dec.word = 1'b1;
        unique case (f3)
          3'b000:  illegal = 1'b0;
          3'b001:  illegal = (funct7 != 7'b0000000);
          3'b101: begin
            illegal    = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            in_dec.alt = ins[30];
          end
          default: illegal = 1'b1;
        endcase
      end
      7'b0110011, 7'b0111011: begin
        in_dec.op_type = OP_INT; in_dec.rs1_en = 1'b1; in_dec.rs2_en = 1'b1; in_dec.rd_wen = 1'b1;
        in_dec.alt  = ins[30];
        in_dec.word = ins[3];
        if (funct7 == 7'b0000000)
          illegal = ins[3] && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
        else if (funct7 == 7'b0100000)
          illegal = !(f3 == 3'b000 || f3 == 3'b101);
        else if (funct7 == 7'b0000001 && M_EN) begin
          in_dec.op_type = OP_MULDIV;
          illegal = ins[3] && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011);
        end else
          illegal = 1'b1;
      end
      7'b0001111: begin in_dec.op_type = OP_FENCE; in_dec.imm = imm_i; end
      7'b1110011: begin
        in_dec.op_type = OP_SYSTEM; in_dec.imm = imm_i;
        in_dec.rd_wen  = (f3[1:0] != 2'b00);
        in_dec.rs1_en  = !f3[2] && (f3[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      in_dec.op_type = OP_ILLEGAL;
      in_dec.rs1_en  = 1'b0;
      in_dec.rs2_en  = 1'b0;
      in_dec.rd_wen  = 1'b0;
      in_dec.alt     = 1'b0;
      in_dec.word    = 1'b0;
      in_dec.imm     = '0;
    end
    if (in_dec.rd == 5'd0) in_dec.rd_wen = 1'b0;
    in_dec.legal = !illegal;
  end

  bundle_t main_q, main_d, skid_q, skid_d;
  logic    main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, ready_q, ready_d;
  logic    fire_in, fire_out;

  assign fire_in  = if_dec_valid & ready_q;
  assign fire_out = main_vld_q & ix_dec_ready;

  always_comb begin : buf_next
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (pipe_flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || fire_out) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_d     = in_dec;
        skid_vld_d = fire_in;
      end else begin
        main_d     = in_dec;
        main_vld_d = fire_in;
      end
    end else if (fire_in) begin
      skid_d     = in_dec;
      skid_vld_d = 1'b1;
    end
    ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst) begin
      // NOTE: the buffer entries are plain flops, so the data is cleared too and the outputs read 0 after reset.
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= ready_d;
    end
  end

  assign if_dec_ready   = ready_q;
  assign dec_ix_valid   = main_vld_q;
  assign dec_ix_pc      = main_q.pc;
  assign dec_ix_op_type = main_q.op_type;
  assign dec_ix_rs1     = main_q.rs1;
  assign dec_ix_rs2     = main_q.rs2;
  assign dec_ix_rd      = main_q.rd;
  assign dec_ix_rs1_en  = main_q.rs1_en;
  assign dec_ix_rs2_en  = main_q.rs2_en;
  assign dec_ix_rd_wen  = main_q.rd_wen;
  assign dec_ix_funct3  = main_q.funct3;
  assign dec_ix_alt     = main_q.alt;
  assign dec_ix_word    = main_q.word;
  assign dec_ix_imm     = main_q.imm;
  assign dec_ix_legal   = main_q.legal;

endmodule

// File: tb/tb_dec.sv
// Scoreboard bench for dec: expectations are built from instruction encodings when an
// instruction is accepted and compared when the decoded bundle leaves the stage.
module tb_dec;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] if_dec_pc;
  logic [31:0] if_dec_instr;
  logic        if_dec_valid, if_dec_ready, pipe_flush;
  logic [63:0] dec_ix_pc, dec_ix_imm;
  logic [3:0]  dec_ix_op_type;
  logic [4:0]  dec_ix_rs1, dec_ix_rs2, dec_ix_rd;
  logic        dec_ix_rs1_en, dec_ix_rs2_en, dec_ix_rd_wen, dec_ix_alt, dec_ix_word;
  logic [2:0]  dec_ix_funct3;
  logic        dec_ix_legal, dec_ix_valid, ix_dec_ready;

  always #5 clk = ~clk;

  dec dut (
    .clk(clk), .rst(rst),
    .if_dec_pc(if_dec_pc), .if_dec_instr(if_dec_instr), .if_dec_valid(if_dec_valid),
    .if_dec_ready(if_dec_ready), .pipe_flush(pipe_flush),
    .dec_ix_pc(dec_ix_pc), .dec_ix_op_type(dec_ix_op_type),
    .dec_ix_rs1(dec_ix_rs1), .dec_ix_rs2(dec_ix_rs2), .dec_ix_rd(dec_ix_rd),
    .dec_ix_rs1_en(dec_ix_rs1_en), .dec_ix_rs2_en(dec_ix_rs2_en), .dec_ix_rd_wen(dec_ix_rd_wen),
    .dec_ix_funct3(dec_ix_funct3), .dec_ix_alt(dec_ix_alt), .dec_ix_word(dec_ix_word),
    .dec_ix_imm(dec_ix_imm), .dec_ix_legal(dec_ix_legal), .dec_ix_valid(dec_ix_valid),
    .ix_dec_ready(ix_dec_ready)
  );

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        rs1_en, rs2_en, rd_wen, alt, word, legal;
    logic [63:0] imm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pops     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

  function automatic exp_t mk(input logic [63:0] pc, input logic [31:0] ins, input logic [3:0] op,
                              input logic r1, input logic r2, input logic wr, input logic al,
                              input logic wd, input logic [63:0] imm);
    exp_t e;
    e.pc = pc; e.op = op; e.imm = imm;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = ins[14:12];
    e.rs1_en = r1; e.rs2_en = r2; e.rd_wen = wr && (ins[11:7] != 5'd0);
    e.alt = al; e.word = wd; e.legal = (op != 4'd15);
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && dec_ix_valid && ix_dec_ready) begin
        pops++;
        if (q.size() == 0) check("spurious_out", 1'b1, 1'b0);
        else begin
          e = q.pop_front();
          check("out_pc", dec_ix_pc, e.pc);
          check("out_imm", dec_ix_imm, e.imm);
          check("out_fields", {dec_ix_op_type, dec_ix_rs1, dec_ix_rs2, dec_ix_rd, dec_ix_funct3},
                {e.op, e.rs1, e.rs2, e.rd, e.f3});
          check("out_flags", {dec_ix_rs1_en, dec_ix_rs2_en, dec_ix_rd_wen, dec_ix_alt, dec_ix_word, dec_ix_legal},
                {e.rs1_en, e.rs2_en, e.rd_wen, e.alt, e.word, e.legal});
        end
      end
    end
  endtask

  task automatic send(input logic [63:0] pc, input logic [31:0] ins, input exp_t e);
    if_dec_pc = pc; if_dec_instr = ins; if_dec_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (if_dec_ready) begin
        q.push_back(e);
        @(posedge clk); #1;
        if_dec_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("send_timeout", 1'b0, 1'b1);
    if_dec_valid = 1'b0;
  endtask

  task automatic send_addi(input logic [63:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [11:0] imm);
    logic [31:0] ins;
    ins = {imm, rs1, 3'b000, rd, 7'b0010011};
    send(pc, ins, mk(pc, ins, 4'd0, 1, 0, 1, 0, 0, sx12(imm)));
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && q.size() != 0; c++) @(negedge clk);
    check("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    logic [63:0] pc;
    logic [11:0] i12;
    logic [20:0] joff;
    logic [12:0] boff;
    logic [4:0]  ra, rb, rc;
    logic [2:0]  f;
    int          base;
    bit          done;

    rst = 1'b0; if_dec_valid = 1'b0; pipe_flush = 1'b0; ix_dec_ready = 1'b0;
    if_dec_pc = '0; if_dec_instr = '0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", dec_ix_valid, 1'b0);
    check("rst_pc", dec_ix_pc, 64'd0);
    check("rst_imm", dec_ix_imm, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", if_dec_ready, 1'b1);
    @(posedge clk); #1;

    // Directed decode cases.
    ix_dec_ready = 1'b1;
    send_addi(64'h1000_0000, 5'd1, 5'd0, 12'd5);
    check("lat1_valid", dec_ix_valid, 1'b1);
    send(64'h1000_0004, 32'hFE208CE3, mk(64'h1000_0004, 32'hFE208CE3, 4'd1, 1, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8));
    send(64'h1000_0008, 32'h0000_0000, mk(64'h1000_0008, 32'h0, 4'd15, 0, 0, 0, 0, 0, 64'd0));
`ifdef DEC_RV64M_EN
    send(64'h1000_000C, 32'h022081B3, mk(64'h1000_000C, 32'h022081B3, 4'd8, 1, 1, 1, 0, 0, 64'd0));
`else
    send(64'h1000_000C, 32'h022081B3, mk(64'h1000_000C, 32'h022081B3, 4'd15, 0, 0, 0, 0, 0, 64'd0));
`endif
    ins = {7'b0100000, 5'd7, 5'd6, 3'b000, 5'd5, 7'b0110011};            // sub x5,x6,x7
    send(64'h20, ins, mk(64'h20, ins, 4'd0, 1, 1, 1, 1, 0, 64'd0));
    ins = {6'b010000, 6'd63, 5'd4, 3'b101, 5'd3, 7'b0010011};            // srai x3,x4,63
    send(64'h24, ins, mk(64'h24, ins, 4'd0, 1, 0, 1, 1, 0, 64'h43F));
    ins = {6'b010000, 6'd1, 5'd4, 3'b001, 5'd3, 7'b0010011};             // bad slli funct6
    send(64'h28, ins, mk(64'h28, ins, 4'd15, 0, 0, 0, 0, 0, 64'd0));
    ins = {7'b0000000, 5'd10, 5'd9, 3'b000, 5'd8, 7'b0111011};           // addw x8,x9,x10
    send(64'h2C, ins, mk(64'h2C, ins, 4'd0, 1, 1, 1, 0, 1, 64'd0));
    ins = {12'hFFF, 5'd2, 3'b000, 5'd1, 7'b0011011};                     // addiw x1,x2,-1
    send(64'h30, ins, mk(64'h30, ins, 4'd0, 1, 0, 1, 0, 1, {64{1'b1}}));
    ins = {12'h340, 5'd5, 3'b001, 5'd0, 7'b1110011};                     // csrrw x0,mscratch,x5
    send(64'h34, ins, mk(64'h34, ins, 4'd9, 1, 0, 1, 0, 0, 64'h340));
    ins = {12'h300, 5'd3, 3'b110, 5'd7, 7'b1110011};                     // csrrsi x7,mstatus,3
    send(64'h38, ins, mk(64'h38, ins, 4'd9, 0, 0, 1, 0, 0, 64'h300));
    send(64'h3C, 32'h0000_0073, mk(64'h3C, 32'h0000_0073, 4'd9, 0, 0, 0, 0, 0, 64'd0));
    send(64'h40, 32'h0000_0012, mk(64'h40, 32'h0000_0012, 4'd15, 0, 0, 0, 0, 0, 64'd0));
    ins = {20'h80000, 5'd2, 7'b0110111};                                 // lui x2,0x80000
    send(64'h44, ins, mk(64'h44, ins, 4'd6, 0, 0, 1, 0, 0, 64'hFFFF_FFFF_8000_0000));
    drain();

    // Stall with 4 addi: main and skid fill, then full-rate delivery.
    ix_dec_ready = 1'b0;
    send_addi(64'h100, 5'd11, 5'd1, 12'd1);
    send_addi(64'h104, 5'd12, 5'd2, 12'd2);
    @(negedge clk);
    check("stall_ready", if_dec_ready, 1'b0);
    check("stall_valid", dec_ix_valid, 1'b1);
    check("stall_rd", dec_ix_rd, 5'd11);
    @(posedge clk); #1;
    base = pops;
    ix_dec_ready = 1'b1;
    fork
      begin
        send_addi(64'h108, 5'd13, 5'd3, 12'd3);
        send_addi(64'h10C, 5'd14, 5'd4, 12'd4);
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        check("full_rate", pops - base, 4);
      end
    join
    drain();

    // Flush with both entries full and a new instruction presented.
    ix_dec_ready = 1'b0;
    send_addi(64'h200, 5'd20, 5'd0, 12'h7FF);
    send_addi(64'h204, 5'd21, 5'd0, 12'h800);
    if_dec_pc = 64'h208; if_dec_instr = 32'h00100093; if_dec_valid = 1'b1; pipe_flush = 1'b1;
    @(posedge clk); #1;
    pipe_flush = 1'b0; if_dec_valid = 1'b0;
    q.delete();
    check("flush2_valid", dec_ix_valid, 1'b0);
    check("flush2_ready", if_dec_ready, 1'b1);

    // Flush while the input would otherwise be accepted.
    send_addi(64'h300, 5'd22, 5'd0, 12'd9);
    if_dec_pc = 64'h304; if_dec_instr = 32'h00100093; if_dec_valid = 1'b1; pipe_flush = 1'b1;
    @(posedge clk); #1;
    pipe_flush = 1'b0; if_dec_valid = 1'b0;
    q.delete();
    check("flush1_valid", dec_ix_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("flush1_stays_empty", dec_ix_valid, 1'b0);
    ix_dec_ready = 1'b1;
    send_addi(64'h400, 5'd23, 5'd5, 12'd42);
    drain();

    // Random mix with random backpressure.
    done = 1'b0;
    fork
      begin
        pc = 64'h8000_0000;
        for (int n = 0; n < 40; n++) begin
          ra = 5'($urandom); rb = 5'($urandom); rc = 5'($urandom); i12 = 12'($urandom);
          case ($urandom_range(0, 3))
            0: send_addi(pc, ra, rb, i12);
            1: begin
              f = 3'($urandom_range(0, 3));
              ins = {i12[11:5], rc, rb, f, i12[4:0], 7'b0100011};
              send(pc, ins, mk(pc, ins, 4'd5, 1, 1, 0, 0, 0, sx12(i12)));
            end
            2: begin
              joff = 21'($urandom); joff[0] = 1'b0;
              ins = {joff[20], joff[10:1], joff[11], joff[19:12], ra, 7'b1101111};
              send(pc, ins, mk(pc, ins, 4'd2, 0, 0, 1, 0, 0, {{43{joff[20]}}, joff}));
            end
            default: begin
              f = 3'($urandom_range(0, 5));
              if (f >= 3'd2) f = f + 3'd2;
              boff = 13'($urandom); boff[0] = 1'b0;
              ins = {boff[12], boff[10:5], rc, rb, f, boff[4:1], boff[11], 7'b1100011};
              send(pc, ins, mk(pc, ins, 4'd1, 1, 1, 0, 0, 0, {{51{boff[12]}}, boff}));
            end
          endcase
          pc = pc + 64'd4;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ix_dec_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ix_dec_ready = 1'b1;
    drain();

    // Reset in the middle of a buffered transfer discards everything.
    ix_dec_ready = 1'b0;
    send_addi(64'h500, 5'd24, 5'd1, 12'd1);
    send_addi(64'h504, 5'd25, 5'd1, 12'd2);
    rst = 1'b0;
    @(posedge clk); #1;
    q.delete();
    check("midrst_valid", dec_ix_valid, 1'b0);
    check("midrst_ready", if_dec_ready, 1'b1);
    check("midrst_pc", dec_ix_pc, 64'd0);
    rst = 1'b1;
    ix_dec_ready = 1'b1;
    send_addi(64'h600, 5'd26, 5'd2, 12'hABC);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
